// File: rtl/neuron_sched_pkg.sv
// -----------------------------------------------------------------------------
// neuron_sched_pkg
//   Shared types and constants for the neuron event scheduler.
//   - sched_state_t   : scheduler FSM states
//   - SYN_GROUP_LOG2  : log2 of neurons covered by one synapse SRAM word
//   - evt_type_bit()  : position of the time-reference flag in an AER address
//   - syn_addr_width(): synapse SRAM word address width for a given M
// -----------------------------------------------------------------------------
package neuron_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYN_RD  = 2'd1,
        S_NEUR_RD = 2'd2,
        S_NEUR_WR = 2'd3
    } sched_state_t;

    // One synapse word holds the weights for 8 consecutive postsynaptic neurons.
    localparam int SYN_GROUP_LOG2 = 3;

    // The AER address is M+1 bits wide; its MSB flags a time-reference event.
    function automatic int evt_type_bit(input int m);
        return m;
    endfunction

    // Synapse word address = {pre[M-1:0], post[M-1:3]}.
    function automatic int syn_addr_width(input int m);
        return 2 * m - SYN_GROUP_LOG2;
    endfunction

endpackage

// File: rtl/neuron_scheduler_spike_fifo.sv
// -----------------------------------------------------------------------------
// spike_fifo
//   Small synchronous FIFO holding indices of neurons that fired.
//   A push while full is accepted only if a pop happens in the same cycle.
//   Ports:
//     CLK, RST      clock, synchronous active-high reset
//     push, din     write request and data
//     pop           read request (ignored while empty)
//     dout          head entry (valid while !empty)
//     full, empty   status flags
//     count         number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module spike_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and an un-reset array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/neuron_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_scheduler
//   Event scheduler and bus arbiter for the time-multiplexed LIF neuron core.
//   Accepts one AER event at a time, walks all N neurons through a read/write
//   pair on the neuron core (preceded by a synapse SRAM read every 8 neurons
//   for synaptic events), and keeps OBI requests off the neuron SRAM while an
//   event is in flight. Neurons that fire are queued and replayed as AER out.
//   Ports:
//     CLK, RST                    clock, synchronous active-high reset
//     aer_valid_i/addr_i/ready_o  input event handshake; addr[M]=1 is a
//                                 time-reference (leak) event
//     bus_req_i / bus_req_o       raw and gated OBI request
//     synarray_cs_o/addr_o        synapse SRAM read port
//     neuron_event_o/write_o/
//     neuron_tref_o/idx_o/count_o neuron core control and target index
//     neuron_spike_i              fire flag from the core during writes
//     aer_out_valid_o/addr_o/
//     aer_out_ready_i             output spike stream
//     busy_o                      high while an event is being processed
// -----------------------------------------------------------------------------
module neuron_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int N          = 256,
    parameter int M          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         aer_valid_i,
    input  logic [M:0]                   aer_addr_i,
    output logic                         aer_ready_o,
    input  logic                         bus_req_i,
    output logic                         bus_req_o,
    output logic                         synarray_cs_o,
    output logic [syn_addr_width(M)-1:0] synarray_addr_o,
    output logic                         neuron_event_o,
    output logic                         neuron_write_o,
    output logic                         neuron_tref_o,
    output logic [M-1:0]                 neuron_idx_o,
    output logic [M-1:0]                 count_o,
    input  logic                         neuron_spike_i,
    output logic                         aer_out_valid_o,
    output logic [M-1:0]                 aer_out_addr_o,
    input  logic                         aer_out_ready_i,
    output logic                         busy_o
);

    localparam int TREF_BIT = evt_type_bit(M);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    sched_state_t     state;
    sched_state_t     next_state;

    logic             last_bus;   // previous IDLE grant went to the bus
    logic             evt_tref;   // latched event type of the current event
    logic [M-1:0]     pre;        // latched presynaptic index
    logic [M-1:0]     idx;        // current postsynaptic neuron

    logic             in_idle;
    logic             grant_bus;
    logic             grant_evt;
    logic             idx_last;
    logic             group_end;
    logic             fifo_room;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // IDLE arbitration: a lone requester wins; on a tie the bus wins unless it
    // also won the previous decision, which alternates the two under load.
    assign in_idle   = (state == S_IDLE);
    assign grant_bus = in_idle && bus_req_i && !(aer_valid_i && last_bus);
    assign grant_evt = in_idle && aer_valid_i && !(bus_req_i && !last_bus);

    assign idx_last  = (idx == M'(N - 1));
    assign group_end = (idx[SYN_GROUP_LOG2-1:0] == '1);

    // A read may start only if the following write can push a spike. No push
    // happens between this check and that write, so the slot stays free.
    assign fifo_room = (fifo_count < CNT_W'(FIFO_DEPTH));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    // ---------------------------------------------------------- next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (grant_evt)
                    next_state = aer_addr_i[TREF_BIT] ? S_NEUR_RD : S_SYN_RD;
            end
            S_SYN_RD: begin
                next_state = S_NEUR_RD;
            end
            S_NEUR_RD: begin
                if (fifo_room) next_state = S_NEUR_WR;
            end
            S_NEUR_WR: begin
                if (idx_last)
                    next_state = S_IDLE;
                else if (!evt_tref && group_end)
                    next_state = S_SYN_RD;   // next neuron needs a new synapse word
                else
                    next_state = S_NEUR_RD;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        synarray_cs_o   = 1'b0;
        synarray_addr_o = '0;
        neuron_event_o  = 1'b0;
        neuron_write_o  = 1'b0;
        unique case (state)
            S_SYN_RD: begin
                synarray_cs_o   = 1'b1;
                synarray_addr_o = {pre, idx[M-1:SYN_GROUP_LOG2]};
            end
            S_NEUR_RD: begin
                neuron_event_o = fifo_room;   // stall cycles keep all strobes low
            end
            S_NEUR_WR: begin
                neuron_event_o = 1'b1;
                neuron_write_o = 1'b1;
            end
            default: ;
        endcase
        neuron_tref_o = neuron_event_o && evt_tref;
    end

    assign aer_ready_o  = grant_evt;
    assign bus_req_o    = grant_bus;
    assign busy_o       = !in_idle;
    assign neuron_idx_o = idx;
    assign count_o      = idx;

    // -------------------------------------------------------------- datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_bus <= 1'b0;
            evt_tref <= 1'b0;
            pre      <= '0;
            idx      <= '0;
        end else begin
            if (grant_bus) last_bus <= 1'b1;
            if (grant_evt) begin
                last_bus <= 1'b0;
                evt_tref <= aer_addr_i[TREF_BIT];
                pre      <= aer_addr_i[M-1:0];
                idx      <= '0;
            end
            if (state == S_NEUR_WR && !idx_last) idx <= idx + M'(1);
        end
    end

    // ------------------------------------------------------- output spike FIFO
    assign fifo_push       = (state == S_NEUR_WR) && neuron_spike_i && !fifo_full;
    assign aer_out_valid_o = !fifo_empty;
    assign fifo_pop        = aer_out_valid_o && aer_out_ready_i;

    spike_fifo #(
        .W     (M),
        .DEPTH (FIFO_DEPTH)
    ) u_spike_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .din   (idx),
        .pop   (fifo_pop),
        .dout  (aer_out_addr_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// tb_neuron_scheduler
//   Scoreboard bench: each accepted event expands (from the event rules) into
//   expected synapse reads, neuron read/write operations and output spikes;
//   a negedge monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_neuron_scheduler;

    localparam int N     = 256;
    localparam int M     = 8;
    localparam int FD    = 4;
    localparam int SAW   = 2 * M - 3;
    localparam int AW    = M + 1;
    localparam int SYN_LAT  = 17 * N / 8;
    localparam int TREF_LAT = 2 * N;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           aer_valid_i = 1'b0;
    logic [M:0]     aer_addr_i = '0;
    logic           aer_ready_o;
    logic           bus_req_i = 1'b0;
    logic           bus_req_o;
    logic           synarray_cs_o;
    logic [SAW-1:0] synarray_addr_o;
    logic           neuron_event_o;
    logic           neuron_write_o;
    logic           neuron_tref_o;
    logic [M-1:0]   neuron_idx_o;
    logic [M-1:0]   count_o;
    logic           neuron_spike_i = 1'b0;
    logic           aer_out_valid_o;
    logic [M-1:0]   aer_out_addr_o;
    logic           aer_out_ready_i = 1'b1;
    logic           busy_o;

    always #5 CLK = ~CLK;

    neuron_scheduler #(.N(N), .M(M), .FIFO_DEPTH(FD)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .aer_valid_i     (aer_valid_i),
        .aer_addr_i      (aer_addr_i),
        .aer_ready_o     (aer_ready_o),
        .bus_req_i       (bus_req_i),
        .bus_req_o       (bus_req_o),
        .synarray_cs_o   (synarray_cs_o),
        .synarray_addr_o (synarray_addr_o),
        .neuron_event_o  (neuron_event_o),
        .neuron_write_o  (neuron_write_o),
        .neuron_tref_o   (neuron_tref_o),
        .neuron_idx_o    (neuron_idx_o),
        .count_o         (count_o),
        .neuron_spike_i  (neuron_spike_i),
        .aer_out_valid_o (aer_out_valid_o),
        .aer_out_addr_o  (aer_out_addr_o),
        .aer_out_ready_i (aer_out_ready_i),
        .busy_o          (busy_o)
    );

    // ------------------------------------------------------------ bookkeeping
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_op  [$];   // expected neuron operations, in order
    int          exp_syn [$];   // expected synapse word addresses
    int          exp_spk [$];   // expected output spike addresses
    bit          spike_pat [N]; // neurons the core model reports as firing
    int          ready_mode = 1; // 0: ready low, 1: ready high, 2: random
    int          bus_viol    = 0;
    int          ready_viol  = 0;
    int          strobe_viol = 0;
    int          wr_seen     = 0;
    logic [31:0] mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] op_word(input logic [M-1:0] idx, input logic [M-1:0] cnt,
                                            input logic wr, input logic tref);
        return {14'd0, idx, cnt, wr, tref};
    endfunction

    // Reference model: an event touches every neuron 0..N-1 with a read then a
    // write; synaptic events fetch one synapse word per block of 8 neurons.
    function automatic void model_event(input logic [M:0] addr);
        bit tref = addr[M];
        int pre  = int'(addr[M-1:0]);
        for (int i = 0; i < N; i++) begin
            if (!tref && (i % 8) == 0) exp_syn.push_back(pre * (N / 8) + i / 8);
            exp_op.push_back(op_word(M'(i), M'(i), 1'b0, tref));
            exp_op.push_back(op_word(M'(i), M'(i), 1'b1, tref));
            if (spike_pat[i]) exp_spk.push_back(i);
        end
    endfunction

    function automatic void clear_pat();
        foreach (spike_pat[i]) spike_pat[i] = 1'b0;
    endfunction

    // ------------------------------------------------ neuron core + sink model
    always begin
        @(posedge CLK);
        #1;
        if (neuron_event_o === 1'b1 && neuron_write_o === 1'b1)
            neuron_spike_i = spike_pat[neuron_idx_o];
        else
            neuron_spike_i = 1'($urandom);   // must be ignored outside writes
        case (ready_mode)
            0:       aer_out_ready_i = 1'b0;
            1:       aer_out_ready_i = 1'b1;
            default: aer_out_ready_i = 1'($urandom);
        endcase
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge CLK) begin
        if (busy_o === 1'b1 && bus_req_o === 1'b1) bus_viol++;
        if (busy_o === 1'b1 && aer_ready_o === 1'b1) ready_viol++;
        if (neuron_event_o !== 1'b1 && (neuron_write_o === 1'b1 || neuron_tref_o === 1'b1))
            strobe_viol++;
        if (synarray_cs_o === 1'b1) begin
            if (exp_syn.size() == 0) check("syn_unexpected", 32'(synarray_addr_o), 32'hFFFF_FFFF);
            else check("syn_addr", 32'(synarray_addr_o), 32'(exp_syn.pop_front()));
        end
        if (neuron_event_o === 1'b1) begin
            if (neuron_write_o === 1'b1) wr_seen++;
            mon_act = op_word(neuron_idx_o, count_o, neuron_write_o, neuron_tref_o);
            if (exp_op.size() == 0) check("op_unexpected", mon_act, 32'hFFFF_FFFF);
            else check("neuron_op", mon_act, exp_op.pop_front());
        end
        if (aer_out_valid_o === 1'b1 && aer_out_ready_i === 1'b1) begin
            if (exp_spk.size() == 0) check("spike_unexpected", 32'(aer_out_addr_o), 32'hFFFF_FFFF);
            else check("spike_addr", 32'(aer_out_addr_o), 32'(exp_spk.pop_front()));
        end
    end

    // ---------------------------------------------------------------- stimulus
    // Present an event until it is granted; returns at posedge+1 after accept.
    task automatic send_event(input logic [M:0] addr, input bit noise);
        bit got = 1'b0;
        @(posedge CLK);
        #1;
        aer_valid_i = 1'b1;
        aer_addr_i  = addr;
        for (int k = 0; k < 32 && !got; k++) begin
            if (noise) bus_req_i = 1'($urandom);
            @(negedge CLK);
            if (aer_ready_o === 1'b1) begin
                model_event(addr);
                got = 1'b1;
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        check("event_accepted", 32'(got), 32'd1);
        @(posedge CLK);
        #1;
        aer_valid_i = 1'b0;
    endtask

    // Count busy cycles until the event finishes; exp_lat of 0 skips the check.
    task automatic wait_done(input int exp_lat, input bit noise);
        int lat  = 0;
        bit done = 1'b0;
        for (int k = 0; k < 20000 && !done; k++) begin
            @(negedge CLK);
            if (busy_o !== 1'b1) done = 1'b1;
            else begin
                lat++;
                @(posedge CLK);
                #1;
                if (noise) bus_req_i = 1'($urandom);
            end
        end
        check("event_done", 32'(done), 32'd1);
        if (exp_lat > 0) check("busy_cycles", 32'(lat), 32'(exp_lat));
        if (noise) bus_req_i = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 1;
        repeat (12) @(posedge CLK);
        check("spikes_drained", 32'(exp_spk.size()), 32'd0);
    endtask

    task automatic check_quiet(input string name);
        check(name, 32'({aer_ready_o, bus_req_o, synarray_cs_o, neuron_event_o, neuron_write_o,
                         neuron_tref_o, aer_out_valid_o, busy_o}), 32'd0);
        check({name, "_idx"}, 32'({neuron_idx_o, count_o, synarray_addr_o}), 32'd0);
    endtask

    initial begin
        int          wr_base;
        bit          found;
        logic [M:0]  addr;
        int          mode;

        clear_pat();

        // Reset values.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_quiet("reset_outputs");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Bus and event both held high: grants alternate bus, event, bus.
        bus_req_i   = 1'b1;
        aer_valid_i = 1'b1;
        aer_addr_i  = 9'h100;
        @(negedge CLK);
        check("arb_first_bus", 32'({bus_req_o, aer_ready_o}), 32'b10);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("arb_second_event", 32'({bus_req_o, aer_ready_o}), 32'b01);
        if (aer_ready_o === 1'b1) model_event(9'h100);
        @(posedge CLK);
        #1;
        wait_done(TREF_LAT, 1'b0);
        check("arb_third_bus", 32'({bus_req_o, aer_ready_o}), 32'b10);
        @(posedge CLK);
        #1;
        bus_req_i   = 1'b0;
        aer_valid_i = 1'b0;

        // Synaptic event from presynaptic neuron 5.
        send_event(9'h005, 1'b0);
        wait_done(SYN_LAT, 1'b0);

        // Time-reference event.
        send_event(9'h100, 1'b0);
        wait_done(TREF_LAT, 1'b0);

        // Spikes on 3, 9, 200 come out in order.
        spike_pat[3] = 1'b1; spike_pat[9] = 1'b1; spike_pat[200] = 1'b1;
        send_event(9'h0C3, 1'b0);
        wait_done(SYN_LAT, 1'b0);
        drain();

        // Back-pressure: every neuron fires, output blocked.
        foreach (spike_pat[i]) spike_pat[i] = 1'b1;
        ready_mode = 0;
        wr_base = wr_seen;
        send_event(9'h100, 1'b0);
        repeat (40) @(negedge CLK);
        check("bp_writes_before_hold", 32'(wr_seen - wr_base), 32'd4);
        check("bp_hold_state", 32'({busy_o, neuron_event_o, aer_out_valid_o}), 32'b101);
        check("bp_fifo_head", 32'(aer_out_addr_o), 32'd0);
        ready_mode = 2;
        wait_done(0, 1'b0);
        drain();
        check("bp_total_writes", 32'(wr_seen - wr_base), 32'(N));

        // Randomized events with bus noise and random output ready.
        for (int r = 0; r < 4; r++) begin
            addr = AW'($urandom_range(0, 2 * N - 1));
            foreach (spike_pat[i]) spike_pat[i] = ($urandom_range(0, 3) == 0);
            mode = int'($urandom_range(1, 2));
            ready_mode = mode;
            send_event(addr, 1'b1);
            wait_done((mode == 1) ? (addr[M] ? TREF_LAT : SYN_LAT) : 0, 1'b1);
            drain();
        end

        // Reset in the middle of a synaptic event.
        clear_pat();
        spike_pat[2] = 1'b1; spike_pat[5] = 1'b1;
        ready_mode = 0;
        send_event(9'h03A, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLK);
            if (neuron_event_o === 1'b1 && neuron_write_o === 1'b0 && neuron_idx_o === 8'd17)
                found = 1'b1;
        end
        check("reached_idx17", 32'(found), 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_op.delete();
        exp_syn.delete();
        exp_spk.delete();
        @(negedge CLK);
        check_quiet("midreset_outputs");
        repeat (5) @(negedge CLK);
        check("midreset_still_idle", 32'(busy_o), 32'd0);

        // A new event is accepted after the abort.
        ready_mode = 1;
        foreach (spike_pat[i]) spike_pat[i] = ($urandom_range(0, 7) == 0);
        send_event(9'h100, 1'b0);
        wait_done(TREF_LAT, 1'b0);
        drain();

        check("no_bus_grant_while_busy", 32'(bus_viol), 32'd0);
        check("no_event_ready_while_busy", 32'(ready_viol), 32'd0);
        check("no_stray_strobes", 32'(strobe_viol), 32'd0);
        check("ops_all_seen", 32'(exp_op.size()), 32'd0);
        check("syn_reads_all_seen", 32'(exp_syn.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
